// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_pkg
// Description : Shared constants and helpers for the valid/ready handshake
//               slices and FIFO, so every block agrees on default widths and
//               on how pointer widths are derived from depth.
//               Contents:
//                 HS_WIDTH       default data width (32)
//                 HS_FIFO_DEPTH  default FIFO depth (4)
//                 hs_clog2()     ceiling log2, used for pointer widths
// Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam int HS_WIDTH      = 32;
    localparam int HS_FIFO_DEPTH = 4;

    // Ceiling log2, usable in constant expressions (parameter derivation).
    function automatic int hs_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_mem
// Description : DEPTH x WIDTH register array for hs_fifo. One synchronous
//               write port and one asynchronous read port. Contents are not
//               reset; validity is tracked by the FIFO control logic.
// Ports       : clk    - clock
//               we     - write enable
//               waddr  - write address (AW bits)
//               wdata  - write data (WIDTH bits)
//               raddr  - read address (AW bits)
//               rdata  - combinational read data (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_FIFO_DEPTH,
    parameter int AW    = hs_clog2(HS_FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/hs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo
// Description : Synchronous valid/ready FIFO. Absorbs bursts while the
//               consumer stalls and presents an ordered, loss-free stream on
//               a valid/ready output port that matches the register slices.
//               No fall-through: a word pushed into an empty FIFO appears on
//               the output one cycle later.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               valid_i  - upstream has data_i available
//               ready_o  - FIFO can accept a word this cycle
//               data_i   - write data (WIDTH bits)
//               valid_o  - data_o holds the oldest stored word
//               ready_i  - downstream accepts data_o this cycle
//               data_o   - read data (WIDTH bits), zero when empty
//               count_o  - stored entries, 0..DEPTH (AW+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_FIFO_DEPTH,
    localparam int AW   = hs_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0]   c_full_cnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW + 1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    assign w_full  = (r_cnt == c_full_cnt);
    assign w_empty = (r_cnt == '0);

    // Gating with rst keeps upstream from seeing a ready that the reset edge
    // would silently discard.
    assign ready_o = !w_full && !rst;
    assign valid_o = !w_empty;

    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            // Pointers wrap by natural AW-bit overflow (DEPTH is a power of 2).
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (data_i),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Stale array contents never leak out while the FIFO is empty.
    assign data_o  = w_empty ? '0 : w_rdata;
    assign count_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/hs_fifo.md
# hs_fifo

Synchronous valid/ready FIFO that sits directly downstream of the handshake register slices. It absorbs bursts when the consumer stalls and presents an ordered, loss-free stream on its own valid/ready output port. Its output port carries the same signal set as the slices, so it chains with them without glue logic.

## Interface
- WIDTH, 32, data width in bits.
- DEPTH, 4, number of entries; a power of two, at least 2.
- AW, $clog2(DEPTH), local parameter; width of the read and write pointers.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- valid_i  input  1  the upstream stage has data_i available.
- ready_o  output  1  the FIFO can accept a word this cycle.
- data_i  input  WIDTH  write data.
- valid_o  output  1  data_o holds the oldest stored word.
- ready_i  input  1  the downstream stage accepts data_o this cycle.
- data_o  output  WIDTH  read data.
- count_o  output  AW+1  number of stored entries, 0..DEPTH.

## Operation
- Push = valid_i && ready_o. Pop = valid_o && ready_i. Both are evaluated on the same rising edge.
- Storage is a DEPTH x WIDTH register array, with write pointer wr_ptr and read pointer rd_ptr, each AW bits wide.
- Each pointer wraps from DEPTH-1 to 0 by natural AW-bit overflow.
- Occupancy counter cnt is AW+1 bits wide and drives count_o.
- cnt update rule:
  - push only: cnt+1
  - pop only: cnt-1
  - push and pop together: unchanged
- full = (cnt == DEPTH). empty = (cnt == 0).
- ready_o = !full && !rst.
- valid_o = !empty.
- data_o = mem[rd_ptr] when not empty, otherwise 0.
- There is no fall-through path. A word written while the FIFO is empty appears on data_o one cycle later.
- Full with pop requested: ready_o stays 0 for that cycle, so no push occurs. The count drops to DEPTH-1 and ready_o rises in the next cycle.
- Empty with valid_i high: push occurs and no pop is possible. The count becomes 1 next cycle.
- Push and pop at any non-full, non-empty level: both pointers advance and the count is held.
- Data ordering is strict FIFO. No word is duplicated or dropped under any valid_i/ready_i pattern.
- The upstream side may drop valid_i or change data_i at any cycle. No upstream hold rule is required, because a word is only captured on a push.
- The downstream side relies on this block's guarantee: once valid_o is high it stays high, with data_o stable, until a pop occurs.

## Timing
- Reset is sampled on a rising edge with rst=1. The next cycle then has:
  - wr_ptr = 0, rd_ptr = 0, cnt = 0
  - valid_o = 0, data_o = 0, count_o = 0
- Memory contents are not reset.
- ready_o is 0 combinationally while rst is high. It is 1 in the first cycle after rst falls.
- Reset asserted mid-operation discards all stored words. The FIFO is empty on the following cycle, and no pop is reported on the reset edge.
- Latency from input to output is 1 cycle: a push at edge N gives valid_o=1 after edge N.
- Throughput is 1 word per cycle sustained when valid_i=1 and ready_i=1, at any count from 1 to DEPTH-1.
- ready_o depends only on registered state and rst. It has no combinational path from ready_i.
- valid_o and data_o depend only on registered state.

## Structure
- A shared package hs_pkg holds the defaults HS_WIDTH=32 and HS_FIFO_DEPTH=4.
- hs_pkg also holds a clog2 helper function for AW, so the slice and FIFO modules share the same constants.
- One sub-module is natural: hs_fifo_mem.
  - DEPTH x WIDTH register array.
  - Write port: we, waddr, wdata.
  - Read port: raddr with asynchronous read.
- Pointer, counter and flag logic live in hs_fifo.

## Test plan
- Reset then idle, with rst=1 for 2 cycles and then released. Required: valid_o=0, count_o=0 and data_o=0 throughout; ready_o=0 during reset and 1 from the first cycle after.
- Fill without draining: ready_i=0, valid_i=1, data_i=1,2,3,4,5 on successive cycles. Required:
  - count_o steps 1..4.
  - ready_o=0 once count_o=4, so word 5 is not accepted.
  - After ready_i=1, data_o reads 1,2,3,4 on consecutive cycles, then valid_o=0.
- Streaming: ready_i=1 and valid_i=1 for 10 cycles with data_i=0x10..0x19. Required:
  - The first valid_o appears one cycle after the first push.
  - Outputs are 0x10..0x19 in order.
  - count_o never exceeds 1.
- Full with pop: fill to 4 with values A..D, then assert valid_i=1 (data E) and ready_i=1 together. Required:
  - A pops and E is not written on that edge.
  - On the next cycle count_o=3 and ready_o=1.
  - E is written on the following edge.
- Wrap-around with random ready_i (50%) and random valid_i over 200 pushes of an incrementing counter. Required: an exact in-order match against a scoreboard, and count_o always equals pushes minus pops.
- Reset mid-operation: hold count_o=3, then pulse rst for 1 cycle. Required:
  - Next cycle count_o=0 and valid_o=0.
  - Subsequent pushes of 0xAA and 0xBB emerge as 0xAA then 0xBB, with no stale data.
